ct_f_spsram_gen: RTL and testbench

Parametrised FPGA single-port SRAM model for the C910 FPGA build. It generalises the fixed-geometry SRAM wrappers in width, depth, write-mask granularity and read pipeline depth. It adds a built-in post-reset initialisation sweep with a busy indication. It sits behind cache/TLB array wrappers and keeps their active-low CEN/GWEN/WEN handshake, so callers change only the instance name and parameters.

---
 rtl/ct_f_spsram_pkg.sv | 19 +
 rtl/ct_f_spsram_lane.sv | 34 +++
 rtl/ct_f_spsram_gen.sv | 128 ++++++++++++
 tb/tb_ct_f_spsram_gen.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/ct_f_spsram_pkg.sv
// Shared types and elaboration helpers for the parametrised FPGA single-port SRAM.
package ct_f_spsram_pkg;

  typedef enum logic [1:0] {
    ST_RESET = 2'd0,
    ST_INIT  = 2'd1,
    ST_READY = 2'd2
  } spsram_state_t;

  function automatic int lane_count(input int data_width, input int lane_width);
    return data_width / lane_width;
  endfunction

  // True when the word splits into whole write-mask lanes.
  function automatic bit lanes_divide(input int data_width, input int lane_width);
    return (lane_width > 0) && ((data_width % lane_width) == 0);
  endfunction

endpackage

// File: rtl/ct_f_spsram_lane.sv
// One write-mask lane: LANE_WIDTH x 2^ADDR_WIDTH storage with a write-through read register.
module ct_f_spsram_lane #(
  parameter int ADDR_WIDTH = 7,
  parameter int LANE_WIDTH = 1
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  EN,
  input  logic                  WE,
  input  logic [ADDR_WIDTH-1:0] A,
  input  logic [LANE_WIDTH-1:0] D,
  output logic [LANE_WIDTH-1:0] Q
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [LANE_WIDTH-1:0] mem [DEPTH];

  // Storage has no reset so it can map onto block RAM; the init sweep fills it.
  always_ff @(posedge CLK) begin
    if (WE) begin
      mem[A] <= D;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      Q <= '0;
    end else if (EN) begin
      Q <= WE ? D : mem[A];
    end
  end

endmodule

// File: rtl/ct_f_spsram_gen.sv
// Parametrised single-port SRAM with post-reset init sweep, per-lane write mask and optional output register.
module ct_f_spsram_gen
  import ct_f_spsram_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 7,
  parameter int                    DATA_WIDTH = 144,
  parameter int                    LANE_WIDTH = 1,
  parameter int                    OUT_REG    = 0,
  parameter logic [LANE_WIDTH-1:0] INIT_VAL   = '0
) (
  input  logic                                          CLK,
  input  logic                                          RST,
  input  logic [ADDR_WIDTH-1:0]                         A,
  input  logic                                          CEN,
  input  logic                                          GWEN,
  input  logic [lane_count(DATA_WIDTH, LANE_WIDTH)-1:0] WEN,
  input  logic [DATA_WIDTH-1:0]                         D,
  output logic [DATA_WIDTH-1:0]                         Q,
  output logic                                          INIT_BUSY,
  output spsram_state_t                                 STATE,
  output logic [ADDR_WIDTH-1:0]                         HELD_A
);

  localparam int                  LANES = lane_count(DATA_WIDTH, LANE_WIDTH);
  localparam int                  DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] LAST  = (ADDR_WIDTH + 1)'(DEPTH - 1);
  localparam logic [ADDR_WIDTH:0] ONE   = (ADDR_WIDTH + 1)'(1);

  if (!lanes_divide(DATA_WIDTH, LANE_WIDTH)) begin : g_bad_lane_width
    $error("ct_f_spsram_gen: DATA_WIDTH must be a multiple of LANE_WIDTH");
  end

  spsram_state_t         state_q;
  logic [ADDR_WIDTH:0]   cnt_q;
  logic                  busy_q;
  logic [ADDR_WIDTH-1:0] held_q;

  // Handshake: CEN=0 requests an access in READY; GWEN=1 reads, GWEN=0 writes the
  // lanes whose WEN bit is 0. Read data appears 1 (OUT_REG=0) or 2 (OUT_REG=1) edges
  // later, one result per accepted access, in order. Nothing is accepted while INIT_BUSY=1.
  logic sweep;
  logic access;
  logic ext_write;

  assign sweep     = (state_q == ST_INIT) && !RST;
  assign access    = (state_q == ST_READY) && !CEN && !RST;
  assign ext_write = access && !GWEN;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= ST_INIT;
      cnt_q   <= '0;
      busy_q  <= 1'b1;
      held_q  <= '0;
    end else begin
      case (state_q)
        ST_INIT: begin
          cnt_q <= cnt_q + ONE;
          if (cnt_q == LAST) begin
            state_q <= ST_READY;
            busy_q  <= 1'b0;
          end
        end
        ST_READY: begin
          if (!CEN) begin
            held_q <= A;
          end
        end
        default: begin
          state_q <= ST_INIT;
          cnt_q   <= '0;
          busy_q  <= 1'b1;
        end
      endcase
    end
  end

  logic [ADDR_WIDTH-1:0] lane_addr;
  logic [LANES-1:0]      lane_we;
  logic [DATA_WIDTH-1:0] lane_d;
  logic [DATA_WIDTH-1:0] rd_data;

  always_comb begin
    lane_addr = A;
    if (sweep) begin
      lane_addr = cnt_q[ADDR_WIDTH-1:0];
    end
  end

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    assign lane_we[k] = sweep || (ext_write && !WEN[k]);
    assign lane_d[k*LANE_WIDTH +: LANE_WIDTH] =
      sweep ? INIT_VAL : D[k*LANE_WIDTH +: LANE_WIDTH];

    ct_f_spsram_lane #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .LANE_WIDTH (LANE_WIDTH)
    ) u_lane (
      .CLK (CLK),
      .RST (RST),
      .EN  (access),
      .WE  (lane_we[k]),
      .A   (lane_addr),
      .D   (lane_d[k*LANE_WIDTH +: LANE_WIDTH]),
      .Q   (rd_data[k*LANE_WIDTH +: LANE_WIDTH])
    );
  end

  // The output stage reloads every cycle; the lane registers hold steady when idle.
  if (OUT_REG != 0) begin : g_out_reg
    logic [DATA_WIDTH-1:0] q_q;
    always_ff @(posedge CLK) begin
      if (RST) begin
        q_q <= '0;
      end else begin
        q_q <= rd_data;
      end
    end
    assign Q = q_q;
  end else begin : g_no_out_reg
    assign Q = rd_data;
  end

  assign INIT_BUSY = RST || busy_q;
  assign STATE     = RST ? ST_RESET : state_q;
  assign HELD_A    = held_q;

endmodule

// File: tb/tb_ct_f_spsram_gen.sv
// Bench for ct_f_spsram_gen: two instances (OUT_REG 0 and 1) against a word-level memory model.
module tb_ct_f_spsram_gen;
  import ct_f_spsram_pkg::*;

  localparam int             AW        = 3;
  localparam int             DW        = 16;
  localparam int             LW        = 4;
  localparam int             NL        = DW / LW;
  localparam int             DEPTH     = 1 << AW;
  localparam logic [DW-1:0]  INIT_WORD = 16'h1111;

  // ---------------- clock / reset / inputs ----------------
  logic          CLK  = 1'b0;
  logic          RST  = 1'b1;
  logic          CEN  = 1'b1;
  logic          GWEN = 1'b1;
  logic [NL-1:0] WEN  = '1;
  logic [AW-1:0] A    = '0;
  logic [DW-1:0] D    = '0;

  always #5 CLK = ~CLK;

  logic [DW-1:0]  q0, q1;
  logic           busy0, busy1;
  spsram_state_t  st0, st1;
  logic [AW-1:0]  ha0, ha1;

  ct_f_spsram_gen #(
    .ADDR_WIDTH (AW), .DATA_WIDTH (DW), .LANE_WIDTH (LW), .OUT_REG (0), .INIT_VAL (4'h1)
  ) dut0 (
    .CLK (CLK), .RST (RST), .A (A), .CEN (CEN), .GWEN (GWEN), .WEN (WEN), .D (D),
    .Q (q0), .INIT_BUSY (busy0), .STATE (st0), .HELD_A (ha0)
  );

  ct_f_spsram_gen #(
    .ADDR_WIDTH (AW), .DATA_WIDTH (DW), .LANE_WIDTH (LW), .OUT_REG (1), .INIT_VAL (4'h1)
  ) dut1 (
    .CLK (CLK), .RST (RST), .A (A), .CEN (CEN), .GWEN (GWEN), .WEN (WEN), .D (D),
    .Q (q1), .INIT_BUSY (busy1), .STATE (st1), .HELD_A (ha1)
  );

  // ---------------- scoreboard counters ----------------
  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [DW-1:0] mdl_mem [DEPTH];
  bit            started = 1'b0;
  bit            m_busy;
  int            sweep_cnt;
  logic [DW-1:0] m_q;
  logic [DW-1:0] m_q1;
  logic [AW-1:0] m_held;

  function automatic logic [DW-1:0] merge(input logic [DW-1:0] old_w, input logic [DW-1:0] new_d,
                                          input logic gwen, input logic [NL-1:0] wen);
    logic [DW-1:0] r;
    r = old_w;
    if (!gwen) begin
      for (int k = 0; k < NL; k++) begin
        if (!wen[k]) r[k*LW +: LW] = new_d[k*LW +: LW];
      end
    end
    return r;
  endfunction

  always @(posedge CLK) begin
    if (RST) begin
      started   <= 1'b1;
      m_busy    <= 1'b1;
      sweep_cnt <= 0;
      m_q       <= '0;
      m_q1      <= '0;
      m_held    <= '0;
    end else if (started) begin
      m_q1 <= m_q;
      if (m_busy) begin
        mdl_mem[sweep_cnt[AW-1:0]] <= INIT_WORD;
        sweep_cnt <= sweep_cnt + 1;
        if (sweep_cnt + 1 == DEPTH) m_busy <= 1'b0;
      end else if (!CEN) begin
        m_held     <= A;
        mdl_mem[A] <= merge(mdl_mem[A], D, GWEN, WEN);
        m_q        <= merge(mdl_mem[A], D, GWEN, WEN);
      end
    end
  end

  // Per-cycle compare, half a cycle away from the active edge.
  always @(negedge CLK) begin
    if (started) begin
      spsram_state_t exp_st;
      exp_st = RST ? ST_RESET : (m_busy ? ST_INIT : ST_READY);
      check("busy0", busy0, RST | m_busy);
      check("busy1", busy1, RST | m_busy);
      check("state0", st0, exp_st);
      check("state1", st1, exp_st);
      check("q_lat1", q0, m_q);
      check("q_lat2", q1, m_q1);
      check("held0", ha0, m_held);
      check("held1", ha1, m_held);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step(input logic rst, input logic cen, input logic gwen, input logic [NL-1:0] wen,
                      input logic [AW-1:0] a, input logic [DW-1:0] d);
    @(negedge CLK);
    #1;
    RST = rst; CEN = cen; GWEN = gwen; WEN = wen; A = a; D = d;
  endtask

  task automatic idle();
    step(1'b0, 1'b1, 1'($urandom_range(0, 1)), NL'($urandom), AW'($urandom), DW'($urandom));
  endtask

  task automatic rd(input logic [AW-1:0] a);
    step(1'b0, 1'b0, 1'b1, NL'($urandom), a, DW'($urandom));
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [NL-1:0] wen);
    step(1'b0, 1'b0, 1'b0, wen, a, d);
  endtask

  // Releases reset, drives DEPTH-1 cycles of writes that must be dropped, then
  // confirms INIT_BUSY falls exactly DEPTH cycles after release.
  task automatic release_and_sweep(input string tag);
    step(1'b0, 1'b1, 1'b1, '1, '0, '0);
    repeat (DEPTH - 1) step(1'b0, 1'b0, 1'b0, '0, 3'd3, 16'hDEAD);
    check({tag, "_busy_at_7"}, busy0, 1'b1);
    idle();
    check({tag, "_busy_at_8"}, busy0, 1'b0);
    check({tag, "_q_zero"}, q0, 16'h0000);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    step(1'b1, 1'b1, 1'b1, '1, '0, '0);
    step(1'b1, 1'b1, 1'b1, '1, '0, '0);
    release_and_sweep("init");

    // Every address holds the init pattern, including 3 which was written during INIT.
    for (int i = 0; i < DEPTH; i++) begin
      rd(AW'(i));
      if (i == 0) check("q_zero_before_read", q0, 16'h0000);
      else check("init_read", q0, INIT_WORD);
    end
    idle();
    check("init_read_last", q0, INIT_WORD);

    // Masked write: lanes 0 and 2 take D, lanes 1 and 3 keep 0x1.
    wr(3'd5, 16'hABCD, 4'b1010);
    idle();
    check("masked_write_through", q0, 16'h1B1D);
    rd(3'd5);
    idle();
    check("masked_read", q0, 16'h1B1D);

    // Back-to-back reads with the 2-cycle pipeline.
    wr(3'd0, 16'h0123, 4'b0000);
    wr(3'd1, 16'h4567, 4'b0000);
    wr(3'd2, 16'h89AB, 4'b0000);
    rd(3'd0);
    rd(3'd1);
    check("lat1_a0", q0, 16'h0123);
    rd(3'd2);
    check("lat2_a0", q1, 16'h0123);
    idle();
    check("lat2_a1", q1, 16'h4567);
    idle();
    check("lat2_a2", q1, 16'h89AB);

    // Hold: CEN high with toggling A/D must not move Q or memory.
    rd(3'd2);
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b1, 1'b0, '0, AW'(i), DW'($urandom));
      if (i > 0) check("hold_q", q0, 16'h89AB);
    end
    rd(3'd2);
    idle();
    check("hold_mem", q0, 16'h89AB);

    // Reset at sweep count 4 restarts the full sweep.
    wr(3'd6, 16'hFFFF, 4'b0000);
    idle();
    step(1'b1, 1'b1, 1'b1, '1, '0, '0);
    step(1'b0, 1'b1, 1'b1, '1, '0, '0);
    repeat (3) idle();
    step(1'b1, 1'b0, 1'b0, '0, 3'd6, 16'hFFFF);
    release_and_sweep("rst_mid");
    rd(3'd6);
    idle();
    check("rst_mid_read6", q0, INIT_WORD);

    // Randomised traffic with rare resets.
    for (int i = 0; i < 600; i++) begin
      step(1'($urandom_range(0, 199) == 0), 1'($urandom_range(0, 3) == 0),
           1'($urandom_range(0, 1)), NL'($urandom), AW'($urandom), DW'($urandom));
    end
    repeat (3) idle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
